vga_scan_out: RTL

VGA_SCAN_OUT -- requirements
Module: vga_scan_out

---
 rtl/vga_pkg.sv | 26 ++
 rtl/sig_delay.sv | 32 +++
 rtl/vga_scan_out.sv | 111 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults and the sync/blank bundle carried down the delay line
package vga_pkg;

    localparam int H_ACTIVE_DEF   = 640;
    localparam int H_FP_DEF       = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BP_DEF       = 48;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int V_FP_DEF       = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BP_DEF       = 33;
    localparam int PIPE_DELAY_DEF = 2;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } vga_sig_t;

    // Blanked with both syncs deasserted (syncs are active-low).
    localparam vga_sig_t SIG_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/sig_delay.sv
// sig_delay: DEPTH-stage shift register with a reset value; DEPTH = 0 is a plain wire
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, loads RST_VAL into every stage
//   d_i   : input word
//   q_o   : input word delayed by DEPTH clocks
module sig_delay #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;
    end else begin : g_pipe
        logic [W-1:0] stage_q [DEPTH];
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end
        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_scan_out.sv
// vga_scan_out: VGA raster counter with sync/blank delayed to line up with pipelined pixel colour
//   clk                    : pixel clock
//   reset                  : asynchronous active-low reset
//   x, y                   : current visible scan position (0 outside the visible area)
//   frame_start            : high while the counters sit at (0,0)
//   r, g, b                : colour returned PIPE_DELAY clocks after x,y
//   vga_r, vga_g, vga_b    : registered colour to the DAC, forced to 0 when blanked
//   vga_hs, vga_vs         : registered active-low syncs
//   vga_blank_n            : registered, high during the visible area
module vga_scan_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       frame_start,
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n
);

    localparam int         LINE_CLKS   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST      = 10'(LINE_CLKS - 1);
    localparam logic [9:0] V_LAST      = 10'(FRAME_LINES - 1);
    localparam logic [9:0] H_VIS       = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS       = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG      = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END      = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG      = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END      = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic       h_vis, v_vis, h_wrap;
    logic [7:0] vga_r_q, vga_g_q, vga_b_q;
    logic       vga_hs_q, vga_vs_q, vga_blank_n_q;
    vga_sig_t   raw, del;

    always_comb begin
        h_wrap      = hcnt_q == H_LAST;
        hcnt_d      = h_wrap ? '0 : hcnt_q + 10'd1;
        vcnt_d      = !h_wrap ? vcnt_q : (vcnt_q == V_LAST ? '0 : vcnt_q + 10'd1);
        h_vis       = hcnt_q < H_VIS;
        v_vis       = vcnt_q < V_VIS;
        x           = h_vis ? hcnt_q : '0;
        y           = v_vis ? vcnt_q[8:0] : '0;
        frame_start = hcnt_q == '0 && vcnt_q == '0;
        raw.active  = h_vis && v_vis;
        raw.hs      = !(hcnt_q >= HS_BEG && hcnt_q < HS_END);
        raw.vs      = !(vcnt_q >= VS_BEG && vcnt_q < VS_END);
    end

    // Timing terms travel alongside the sprite pipeline so they meet r,g,b for the same pixel.
    sig_delay #(
        .W       ($bits(vga_sig_t)),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SIG_IDLE)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .d_i   (raw),
        .q_o   (del)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            vga_r_q       <= '0;
            vga_g_q       <= '0;
            vga_b_q       <= '0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            vga_blank_n_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            vga_r_q       <= del.active ? r : '0;
            vga_g_q       <= del.active ? g : '0;
            vga_b_q       <= del.active ? b : '0;
            vga_hs_q      <= del.hs;
            vga_vs_q      <= del.vs;
            vga_blank_n_q <= del.active;
        end
    end

    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_blank_n = vga_blank_n_q;

endmodule
